// File: rtl/aes256_dec_seq_pkg.sv
// Shared types, sizes and GF(2^8) helpers for the iterative AES-256 decryption sequencer.
package aes_dec_pkg;

   localparam int AES256_NR       = 14;
   localparam int AES256_NK_STEPS = 7;

   typedef logic [127:0] aes_block_t;
   typedef logic [255:0] aes_key_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_KEYEXP,
      ST_READY,
      ST_ROUND,
      ST_HOLD
   } aes_dec_state_e;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] sq;
      r  = 8'h01;
      sq = a;
      for (int i = 0; i < 8; i++) begin
         if (i != 0) r = gf_mul(r, sq);
         sq = gf_mul(sq, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] v;
      v = gf_inv(x);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      logic [7:0] y;
      y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
      return gf_inv(y);
   endfunction

endpackage

// File: rtl/aes256_dec_seq_if.sv
// Key, ciphertext and plaintext handshake bundle of the AES-256 decryption sequencer.
interface aes256_dec_seq_if;
   import aes_dec_pkg::*;

   aes_key_t   key;
   logic       key_valid;
   logic       key_ready;
   aes_block_t datain;
   logic       in_valid;
   logic       in_ready;
   aes_block_t dataout;
   logic       out_valid;
   logic       out_ready;
   logic       key_loaded;

   modport master (
      output key, key_valid, datain, in_valid, out_ready,
      input  key_ready, in_ready, dataout, out_valid, key_loaded
   );

   modport slave (
      input  key, key_valid, datain, in_valid, out_ready,
      output key_ready, in_ready, dataout, out_valid, key_loaded
   );
endinterface

// File: rtl/aes_dec_round_core.sv
// Combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
module aes_dec_round_core
   import aes_dec_pkg::*;
(
   input  aes_block_t state_in,
   input  aes_block_t rkey,
   input  logic       last,
   output aes_block_t state_out
);
   logic [7:0] ark [0:15];
   aes_block_t ark_flat;
   aes_block_t mixed;

   genvar gi;
   generate
      // Byte gi = row gi%4, column gi/4; row r is rotated right by r columns.
      for (gi = 0; gi < 16; gi++) begin : g_byte
         localparam int SRC = 4 * (((gi / 4) + 4 - (gi % 4)) % 4) + (gi % 4);
         assign ark[gi] = inv_sbox(state_in[127-8*SRC -: 8]) ^ rkey[127-8*gi -: 8];
         assign ark_flat[127-8*gi -: 8] = ark[gi];
      end
      for (gi = 0; gi < 4; gi++) begin : g_col
         logic [7:0] a0, a1, a2, a3;
         assign a0 = ark[4*gi];
         assign a1 = ark[4*gi+1];
         assign a2 = ark[4*gi+2];
         assign a3 = ark[4*gi+3];
         assign mixed[127-32*gi -: 32] = {
            gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
      end
   endgenerate

   assign state_out = last ? ark_flat : mixed;
endmodule

// File: rtl/aes_key_expansion.sv
// One AES-256 key-schedule step: eight words in, the next eight words out, rcon = 2^rc.
module aes_key_expansion
   import aes_dec_pkg::*;
(
   input  aes_key_t   key_in,
   input  logic [2:0] rc,
   output aes_key_t   key_out
);
   logic [31:0] w_in  [0:7];
   logic [31:0] w_out [0:7];
   logic [31:0] rot;
   logic [31:0] sub_hi;
   logic [31:0] sub_lo;
   logic [7:0]  rcon;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_word
         assign w_in[gi] = key_in[255-32*gi -: 32];
         assign key_out[255-32*gi -: 32] = w_out[gi];
      end
   endgenerate

   assign rot  = {w_in[7][23:0], w_in[7][31:24]};
   assign rcon = 8'h01 << rc;
   assign sub_hi = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
   assign sub_lo = {sbox(w_out[3][31:24]), sbox(w_out[3][23:16]), sbox(w_out[3][15:8]), sbox(w_out[3][7:0])};

   // Word 4 of the new half takes SubWord of word 3 without rotation or rcon.
   assign w_out[0] = w_in[0] ^ sub_hi ^ {rcon, 24'h000000};
   assign w_out[1] = w_in[1] ^ w_out[0];
   assign w_out[2] = w_in[2] ^ w_out[1];
   assign w_out[3] = w_in[3] ^ w_out[2];
   assign w_out[4] = w_in[4] ^ sub_lo;
   assign w_out[5] = w_in[5] ^ w_out[4];
   assign w_out[6] = w_in[6] ^ w_out[5];
   assign w_out[7] = w_in[7] ^ w_out[6];
endmodule

// File: rtl/aes256_dec_seq.sv
// Iterative AES-256 decryptor: 7-cycle key expansion into rk[0..14], then 14 inverse rounds per block.
// Optional AES_DEC_ZEROIZE_EN adds a zeroize input that wipes all key and data state.
module aes256_dec_seq
   import aes_dec_pkg::*;
(
   input  logic clk,
   input  logic rst,
`ifdef AES_DEC_ZEROIZE_EN
   input  logic zeroize,
`endif
   aes256_dec_seq_if.slave bus
);
   localparam logic [2:0] IDLE   = ST_IDLE;
   localparam logic [2:0] KEYEXP = ST_KEYEXP;
   localparam logic [2:0] READY  = ST_READY;
   localparam logic [2:0] ROUND  = ST_ROUND;
   localparam logic [2:0] HOLD   = ST_HOLD;

   logic [2:0] state_reg;
   aes_block_t rk_reg [0:AES256_NR];
   aes_key_t   exp_reg;
   aes_key_t   exp_next;
   logic [2:0] step_reg;
   logic [3:0] rnd_reg;
   aes_block_t blk_reg;
   aes_block_t dataout_reg;
   aes_block_t core_out;
   logic       out_valid_reg;
   logic       key_loaded_reg;
   logic       key_rdy;
   logic       in_rdy;
   logic       key_hs;
   logic       in_hs;
   logic       last_round;
   logic [3:0] wr_idx;

   // A pending key always wins over a pending block.
   assign key_rdy    = (state_reg == IDLE) || (state_reg == READY);
   assign in_rdy     = (state_reg == READY) && !bus.key_valid;
   assign key_hs     = bus.key_valid && key_rdy;
   assign in_hs      = bus.in_valid && in_rdy;
   assign last_round = (rnd_reg == 4'(AES256_NR));
   assign wr_idx     = {step_reg, 1'b0} + 4'd2;

   assign bus.key_ready  = key_rdy;
   assign bus.in_ready   = in_rdy;
   assign bus.dataout    = dataout_reg;
   assign bus.out_valid  = out_valid_reg;
   assign bus.key_loaded = key_loaded_reg;

   aes_dec_round_core u_core (
      .state_in  (blk_reg),
      .rkey      (rk_reg[4'(AES256_NR) - rnd_reg]),
      .last      (last_round),
      .state_out (core_out)
   );

   aes_key_expansion u_kexp (
      .key_in  (exp_reg),
      .rc      (step_reg),
      .key_out (exp_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i <= AES256_NR; i++) rk_reg[i] <= '0;
         state_reg <= IDLE;    exp_reg <= '0;     step_reg <= '0;    rnd_reg <= '0;
         blk_reg <= '0;        dataout_reg <= '0; out_valid_reg <= 1'b0; key_loaded_reg <= 1'b0;
`ifdef AES_DEC_ZEROIZE_EN
      end else if (zeroize) begin
         for (int i = 0; i <= AES256_NR; i++) rk_reg[i] <= '0;
         state_reg <= IDLE;    exp_reg <= '0;     step_reg <= '0;    rnd_reg <= '0;
         blk_reg <= '0;        dataout_reg <= '0; out_valid_reg <= 1'b0; key_loaded_reg <= 1'b0;
`endif
      end else if (key_hs) begin
         rk_reg[0]      <= bus.key[255:128];
         rk_reg[1]      <= bus.key[127:0];
         exp_reg        <= bus.key;
         step_reg       <= '0;
         key_loaded_reg <= 1'b0;
         state_reg      <= KEYEXP;
      end else begin
         case (state_reg)
            KEYEXP: begin
               rk_reg[wr_idx] <= exp_next[255:128];
               exp_reg        <= exp_next;
               // The final step only supplies rk[14]; its lower half is not a round key.
               if (step_reg == 3'(AES256_NK_STEPS - 1)) begin
                  key_loaded_reg <= 1'b1;
                  state_reg      <= READY;
               end else begin
                  rk_reg[wr_idx + 4'd1] <= exp_next[127:0];
                  step_reg              <= step_reg + 3'd1;
               end
            end
            READY: begin
               if (in_hs) begin
                  blk_reg   <= bus.datain ^ rk_reg[AES256_NR];
                  rnd_reg   <= 4'd1;
                  state_reg <= ROUND;
               end
            end
            ROUND: begin
               if (last_round) begin
                  dataout_reg   <= core_out;
                  out_valid_reg <= 1'b1;
                  state_reg     <= HOLD;
               end else begin
                  blk_reg <= core_out;
                  rnd_reg <= rnd_reg + 4'd1;
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  out_valid_reg <= 1'b0;
                  state_reg     <= READY;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_aes256_dec_seq.sv
// Scoreboard bench for aes256_dec_seq: table-driven AES-256 reference, random keys/blocks/backpressure.
module tb_aes256_dec_seq;

   localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;

   logic clk = 1'b0;
   logic rst = 1'b1;
`ifdef AES_DEC_ZEROIZE_EN
   logic zeroize = 1'b0;
`endif
   always #5 clk = ~clk;

   aes256_dec_seq_if bus_if();

   aes256_dec_seq dut (
      .clk     (clk),
      .rst     (rst),
`ifdef AES_DEC_ZEROIZE_EN
      .zeroize (zeroize),
`endif
      .bus     (bus_if)
   );

   logic ready_fix  = 1'b1;
   logic ready_rand = 1'b1;
   logic rand_en    = 1'b0;
   assign bus_if.out_ready = rand_en ? ready_rand : ready_fix;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [127:0] pt;
      int           hs;
   } exp_t;
   exp_t sb_q[$];

   logic [7:0]   sbox_t     [0:255];
   logic [7:0]   inv_sbox_t [0:255];
   logic [255:0] model_key;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: DUT event not seen within cycle budget", name);
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r = r ^ x;
         x = xt(x);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   // S-box from the generator-3 walk over GF(2^8), then inverted as a lookup table.
   task automatic build_tables();
      logic [7:0] p = 8'h01;
      logic [7:0] q = 8'h01;
      for (int k = 0; k < 255; k++) begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b00};
         q = q ^ {q[3:0], 4'h0};
         if (q[7]) q = q ^ 8'h09;
         sbox_t[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
      end
      sbox_t[0] = 8'h63;
      for (int i = 0; i < 256; i++) inv_sbox_t[sbox_t[i]] = 8'(i);
   endtask

   function automatic logic [31:0] subw(input logic [31:0] v);
      return {sbox_t[v[31:24]], sbox_t[v[23:16]], sbox_t[v[15:8]], sbox_t[v[7:0]]};
   endfunction

   function automatic logic [127:0] ref_decrypt(input logic [255:0] k, input logic [127:0] ct);
      logic [31:0]  w [0:59];
      logic [7:0]   s [0:15];
      logic [7:0]   t [0:15];
      logic [7:0]   a [0:3];
      logic [7:0]   rcon = 8'h01;
      logic [31:0]  tmp;
      logic [127:0] res;
      for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
      for (int i = 8; i < 60; i++) begin
         tmp = w[i-1];
         if (i % 8 == 0) begin
            tmp  = subw({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
            rcon = xt(rcon);
         end else if (i % 8 == 4) begin
            tmp = subw(tmp);
         end
         w[i] = w[i-8] ^ tmp;
      end
      for (int j = 0; j < 16; j++) s[j] = ct[127-8*j -: 8] ^ w[56 + j/4][31-8*(j%4) -: 8];
      for (int r = 13; r >= 0; r--) begin
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
               t[4*c+row] = inv_sbox_t[s[4*((c + 4 - row) % 4) + row]];
         for (int j = 0; j < 16; j++) s[j] = t[j] ^ w[4*r + j/4][31-8*(j%4) -: 8];
         if (r > 0) begin
            for (int c = 0; c < 4; c++) begin
               for (int m = 0; m < 4; m++) a[m] = s[4*c+m];
               s[4*c]   = gm(a[0], 14) ^ gm(a[1], 11) ^ gm(a[2], 13) ^ gm(a[3], 9);
               s[4*c+1] = gm(a[0], 9)  ^ gm(a[1], 14) ^ gm(a[2], 11) ^ gm(a[3], 13);
               s[4*c+2] = gm(a[0], 13) ^ gm(a[1], 9)  ^ gm(a[2], 14) ^ gm(a[3], 11);
               s[4*c+3] = gm(a[0], 11) ^ gm(a[1], 13) ^ gm(a[2], 9)  ^ gm(a[3], 14);
            end
         end
      end
      for (int j = 0; j < 16; j++) res[127-8*j -: 8] = s[j];
      return res;
   endfunction

   // ---------------- monitor ----------------
   logic seen_valid = 1'b0;
   always @(negedge clk) begin
      if (rst || !bus_if.out_valid) begin
         seen_valid = 1'b0;
      end else if (sb_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL unexpected_output: dataout %h with no block outstanding", bus_if.dataout);
      end else begin
         if (!seen_valid) begin
            check("latency", 256'(cyc - sb_q[0].hs), 256'd14);
            seen_valid = 1'b1;
         end
         if (bus_if.out_ready) begin
            check("dataout", bus_if.dataout, sb_q[0].pt);
            $display("[TB] block out %h (hs cycle %0d)", bus_if.dataout, sb_q[0].hs);
            void'(sb_q.pop_front());
            seen_valid = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1 ready_rand = 1'($urandom_range(0, 1));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_key(input logic [255:0] k, output int hs);
      int n = 0;
      bus_if.key       = k;
      bus_if.key_valid = 1'b1;
      hs = -1;
      forever begin
         @(negedge clk);
         if (bus_if.key_ready) break;
         n++;
         if (n > 400) begin
            timeout_fail("key_handshake");
            bus_if.key_valid = 1'b0;
            return;
         end
      end
      tick();
      hs = cyc;
      bus_if.key_valid = 1'b0;
      model_key = k;
      $display("[TB] key load %h at cycle %0d", k, hs);
   endtask

   task automatic send_block(input logic [127:0] ct, output int hs);
      int n = 0;
      bus_if.datain   = ct;
      bus_if.in_valid = 1'b1;
      hs = -1;
      forever begin
         @(negedge clk);
         if (bus_if.in_ready) break;
         n++;
         if (n > 400) begin
            timeout_fail("block_handshake");
            bus_if.in_valid = 1'b0;
            return;
         end
      end
      tick();
      hs = cyc;
      bus_if.in_valid = 1'b0;
      sb_q.push_back('{pt: ref_decrypt(model_key, ct), hs: hs});
      $display("[TB] block in %h at cycle %0d", ct, hs);
   endtask

   task automatic wait_out_valid();
      for (int n = 0; n <= 400; n++) begin
         @(negedge clk);
         if (bus_if.out_valid) return;
      end
      timeout_fail("out_valid_wait");
   endtask

   task automatic wait_drain();
      for (int n = 0; n <= 2000; n++) begin
         @(negedge clk);
         if (sb_q.size() == 0) begin
            tick();
            return;
         end
      end
      timeout_fail("scoreboard_drain");
   endtask

   initial begin
      int hs_a, hs_b, hk;
      logic [255:0] rk;
      logic [127:0] ct;

      build_tables();
      bus_if.key       = '0;
      bus_if.key_valid = 1'b0;
      bus_if.datain    = '0;
      bus_if.in_valid  = 1'b0;
      model_key        = '0;

      // reset state
      tick();
      tick();
      check("rst_dataout", bus_if.dataout, 0);
      check("rst_out_valid", bus_if.out_valid, 0);
      check("rst_key_loaded", bus_if.key_loaded, 0);
      check("rst_key_ready", bus_if.key_ready, 1);
      check("rst_in_ready", bus_if.in_ready, 0);
      rst = 1'b0;
      tick();

      // key expansion timing: key_loaded rises after edge 7
      load_key(C3_KEY, hk);
      for (int e = 1; e <= 7; e++) begin
         tick();
         check($sformatf("key_loaded_e%0d", e), bus_if.key_loaded, (e == 7) ? 1 : 0);
         if (e < 7) check($sformatf("keyexp_key_ready_e%0d", e), bus_if.key_ready, 0);
      end
      check("ready_in_ready", bus_if.in_ready, 1);

      // FIPS-197 C.3 under 20 cycles of backpressure
      ready_fix = 1'b0;
      send_block(C3_CT, hs_a);
      wait_out_valid();
      for (int i = 0; i < 20; i++) begin
         check("hold_dataout", bus_if.dataout, C3_PT);
         check("hold_in_ready", bus_if.in_ready, 0);
         check("hold_out_valid", bus_if.out_valid, 1);
         tick();
      end
      ready_fix = 1'b1;
      tick();
      check("hold_release_in_ready", bus_if.in_ready, 1);
      check("hold_release_out_valid", bus_if.out_valid, 0);

      // back-to-back blocks: 14 rounds + 1 HOLD + 1 READY between acceptances
      send_block(C3_CT, hs_a);
      send_block(C3_CT, hs_b);
      check("b2b_spacing", 256'(hs_b - hs_a), 256'd16);
      wait_drain();

      // random keys and blocks with random output backpressure
      rand_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         rk = {$urandom(), $urandom(), $urandom(), $urandom(),
               $urandom(), $urandom(), $urandom(), $urandom()};
         load_key(rk, hk);
         for (int b = 0; b < 3; b++) begin
            ct = {$urandom(), $urandom(), $urandom(), $urandom()};
            send_block(ct, hs_a);
         end
      end
      wait_drain();
      rand_en = 1'b0;
      tick();

      // key and block offered together in READY: key first, block after re-expansion
      rk = {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
      ct = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus_if.key       = rk;
      bus_if.key_valid = 1'b1;
      bus_if.datain    = ct;
      bus_if.in_valid  = 1'b1;
      @(negedge clk);
      check("prio_in_ready", bus_if.in_ready, 0);
      check("prio_key_ready", bus_if.key_ready, 1);
      tick();
      hk = cyc;
      bus_if.key_valid = 1'b0;
      model_key = rk;
      check("prio_key_loaded_e0", bus_if.key_loaded, 0);
      for (int e = 1; e < 7; e++) begin
         tick();
         check($sformatf("prio_key_loaded_e%0d", e), bus_if.key_loaded, 0);
         check($sformatf("prio_in_ready_e%0d", e), bus_if.in_ready, 0);
      end
      send_block(ct, hs_a);
      check("prio_block_accept_edge", 256'(hs_a - hk), 256'd8);
      wait_drain();

      // reset in the middle of round 7, then reload and rerun
      load_key(C3_KEY, hk);
      send_block(C3_CT, hs_a);
      for (int i = 0; i < 6; i++) tick();
      rst = 1'b1;
      #1;
      check("midrst_out_valid", bus_if.out_valid, 0);
      check("midrst_key_loaded", bus_if.key_loaded, 0);
      check("midrst_key_ready", bus_if.key_ready, 1);
      check("midrst_in_ready", bus_if.in_ready, 0);
      sb_q.delete();
      tick();
      rst = 1'b0;
      tick();
      load_key(C3_KEY, hk);
      send_block(C3_CT, hs_a);
      wait_out_valid();
      check("kat_after_reset", bus_if.dataout, C3_PT);
      wait_drain();

`ifdef AES_DEC_ZEROIZE_EN
      // zeroize while a result is held
      ready_fix = 1'b0;
      send_block(C3_CT, hs_a);
      wait_out_valid();
      tick();
      zeroize = 1'b1;
      tick();
      zeroize = 1'b0;
      sb_q.delete();
      check("zeroize_out_valid", bus_if.out_valid, 0);
      check("zeroize_dataout", bus_if.dataout, 0);
      check("zeroize_key_loaded", bus_if.key_loaded, 0);
      check("zeroize_key_ready", bus_if.key_ready, 1);
      for (int i = 0; i < 15; i++) check($sformatf("zeroize_rk%0d", i), dut.rk_reg[i], 0);
      ready_fix = 1'b1;
      tick();
`endif

      check("scoreboard_empty", 256'(sb_q.size()), 256'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
